// File: rtl/lockin_mem_pkg.sv
// Shared SPRAM geometry and read-master state encoding.
// Reused by every SPRAM client so address/data widths stay in one place.
package lockin_mem_pkg;

    localparam int SPRAM_ADDR_W = 14;
    localparam int SPRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        CSUM  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/spram_burst_reader_if.sv
// Control, SPRAM and output-stream signals of the burst reader.
// master = reader side, slave = requester / memory / sink side.
interface spram_burst_reader_if #(
    parameter int ADDR_W = lockin_mem_pkg::SPRAM_ADDR_W,
    parameter int DATA_W = lockin_mem_pkg::SPRAM_DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ce;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  start, base_addr, length, mem_rdata, out_ready,
        output busy, done, mem_addr, mem_ce, mem_wren, out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, length, mem_rdata, out_ready,
        input  busy, done, mem_addr, mem_ce, mem_wren, out_data, out_valid, out_last
    );
endinterface

// File: rtl/spram_rd_skid_fifo.sv
// Two-entry skid FIFO holding {last, data}; head is visible combinationally.
// Push and pop may coincide; push while full without pop and pop while empty are dropped.
module spram_rd_skid_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_dat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_dat   = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

// File: rtl/spram_burst_reader.sv
// SPRAM burst read master: start -> first out_valid 3 cycles later, one word/cycle when ready,
// reads throttled so issued-but-unconsumed words never exceed 2. SPRAM_READER_CHECKSUM_EN appends a sum word.
module spram_burst_reader
    import lockin_mem_pkg::*;
#(
    parameter int ADDR_W = SPRAM_ADDR_W,
    parameter int DATA_W = SPRAM_DATA_W
) (
    input  logic clk,
    input  logic rst,
    spram_burst_reader_if.master bus
);
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rem;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic [DATA_W:0]   w_fifo_dat;
    logic [1:0]        w_fifo_cnt;
    logic              w_fifo_vld;
    logic              w_fifo_pop;
    logic              w_last_pop;
    logic              w_csum_pop;
    logic [2:0]        w_occ;
    logic              w_issue;

`ifdef SPRAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    spram_rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_dat   ({r_inflight_last, bus.mem_rdata}),
        .i_pop   (w_fifo_pop),
        .o_dat   (w_fifo_dat),
        .o_count (w_fifo_cnt)
    );

    // Built from FIFO state and out_ready only, so mem_ce has no path through out_valid.
    assign w_fifo_vld = (w_fifo_cnt != 2'd0);
    assign w_fifo_pop = w_fifo_vld && bus.out_ready;
    assign w_last_pop = w_fifo_pop && w_fifo_dat[DATA_W];
    assign w_csum_pop = (r_state == CSUM) && bus.out_ready;
    assign w_occ      = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_fifo_pop};
    assign w_issue    = (r_state == RUN) && (w_occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start && (bus.length != '0)) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_issue && (r_rem == REM_ONE)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_pop) begin
`ifdef SPRAM_READER_CHECKSUM_EN
                    w_next = CSUM;
`else
                    w_next = IDLE;
`endif
                end
            end
            CSUM: begin
                if (w_csum_pop) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem == REM_ONE);
            if ((r_state == IDLE) && bus.start) begin
                r_addr <= bus.base_addr;
                r_rem  <= bus.length;
                if (bus.length == '0) begin
                    r_done <= 1'b1;
                end
            end
            if (w_issue) begin
                r_addr <= r_addr + ADDR_ONE;
                r_rem  <= r_rem - REM_ONE;
            end
            if ((r_state != IDLE) && (w_next == IDLE)) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef SPRAM_READER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_sum <= '0;
        end else if (w_fifo_pop) begin
            r_sum <= r_sum + w_fifo_dat[DATA_W-1:0];
        end
    end
`endif

    always_comb begin
        bus.busy      = (r_state != IDLE);
        bus.done      = r_done;
        bus.mem_addr  = r_addr;
        bus.mem_ce    = w_issue;
        bus.mem_wren  = 1'b0;
        bus.out_valid = w_fifo_vld;
        bus.out_data  = w_fifo_dat[DATA_W-1:0];
`ifdef SPRAM_READER_CHECKSUM_EN
        // Data words never carry last here; the sum word closes the burst.
        bus.out_last  = 1'b0;
        if (r_state == CSUM) begin
            bus.out_valid = 1'b1;
            bus.out_data  = r_sum;
            bus.out_last  = 1'b1;
        end
`else
        bus.out_last  = w_fifo_vld && w_fifo_dat[DATA_W];
`endif
    end
endmodule

// File: tb/tb_spram_burst_reader.sv
// Directed bench for spram_burst_reader: cycle tables for fixed bursts plus
// hand-written random-backpressure, reset-abort and restart sequences.
module tb_spram_burst_reader;
    import lockin_mem_pkg::*;

`ifdef SPRAM_READER_CHECKSUM_EN
    localparam logic CS = 1'b1;
`else
    localparam logic CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spram_burst_reader_if bus ();

    spram_burst_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [16384];
    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 16'(a) ^ 16'hA5A5;
    end
    always @(posedge clk) begin
        if (bus.mem_ce) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          scn;
        int          cyc;
        logic        ce;
        logic [13:0] addr;
        logic        busy;
        logic        done;
        logic        vld;
        logic [15:0] dat;
        logic        last;
    } vec_t;

    vec_t vt[$];

    logic        tr_ce   [16];
    logic [13:0] tr_addr [16];
    logic        tr_busy [16];
    logic        tr_done [16];
    logic        tr_vld  [16];
    logic [15:0] tr_dat  [16];
    logic        tr_last [16];
    logic        tr_wren [16];

    task automatic run_trace(input logic [13:0] b, input logic [14:0] l);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = b; bus.length = l; bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tr_ce[c] = bus.mem_ce;     tr_addr[c] = bus.mem_addr;
            tr_busy[c] = bus.busy;     tr_done[c] = bus.done;
            tr_vld[c] = bus.out_valid; tr_dat[c] = bus.out_data;
            tr_last[c] = bus.out_last; tr_wren[c] = bus.mem_wren;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic check_scn(input int s);
        foreach (vt[i]) begin
            if (vt[i].scn == s) begin
                int c;
                c = vt[i].cyc;
                chk($sformatf("s%0d c%0d mem_ce", s, c), tr_ce[c], vt[i].ce);
                if (vt[i].ce) chk($sformatf("s%0d c%0d mem_addr", s, c), tr_addr[c], vt[i].addr);
                chk($sformatf("s%0d c%0d busy", s, c), tr_busy[c], vt[i].busy);
                chk($sformatf("s%0d c%0d done", s, c), tr_done[c], vt[i].done);
                chk($sformatf("s%0d c%0d out_valid", s, c), tr_vld[c], vt[i].vld);
                chk($sformatf("s%0d c%0d mem_wren", s, c), tr_wren[c], 1'b0);
                if (vt[i].vld) begin
                    chk($sformatf("s%0d c%0d out_data", s, c), tr_dat[c], vt[i].dat);
                    chk($sformatf("s%0d c%0d out_last", s, c), tr_last[c], vt[i].last);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"}, bus.busy, 1'b0);
        chk({tag, " done"}, bus.done, 1'b0);
        chk({tag, " mem_ce"}, bus.mem_ce, 1'b0);
        chk({tag, " out_valid"}, bus.out_valid, 1'b0);
        chk({tag, " out_last"}, bus.out_last, 1'b0);
        chk({tag, " mem_addr"}, bus.mem_addr, 14'h0);
        chk({tag, " out_data"}, bus.out_data, 16'h0);
        chk({tag, " mem_wren"}, bus.mem_wren, 1'b0);
    endtask

    // Random backpressure, 64 words, plus an ignored start mid-burst.
    task automatic t_backpressure();
        int issued = 0, got = 0, maxout = 0, viol = 0, n_exp;
        logic [15:0] sum = 16'h0, expw, pd = 16'h0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0, seen = 1'b0;
        n_exp = 64 + int'(CS);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 14'h0010; bus.length = 15'd64;
        bus.out_ready = 1'($urandom_range(0, 1));
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (pv && !pr && (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_last !== pl))
                viol++;
            if (bus.mem_ce) begin
                if (bus.mem_addr !== 14'(16 + issued)) viol++;
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                expw = (got < 64) ? (16'(16 + got) ^ 16'hA5A5) : sum;
                chk($sformatf("bp word%0d", got), bus.out_data, expw);
                if (got == n_exp - 1) chk("bp final out_last", bus.out_last, 1'b1);
                else if (bus.out_last) viol++;
                if (got < 64) sum = sum + expw;
                got++;
            end
            if (issued - got > maxout) maxout = issued - got;
            if (bus.done) seen = 1'b1;
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (c == 9) begin
                bus.start = 1'b1; bus.base_addr = 14'h0100; bus.length = 15'd3;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        chk("bp done seen", seen, 1'b1);
        chk("bp words delivered", got, n_exp);
        chk("bp reads issued", issued, 64);
        chk("bp outstanding within 2", (maxout <= 2), 1'b1);
        chk("bp stability/addr/last violations", viol, 0);
        bus.out_ready = 1'b1;
    endtask

    // Reset mid-burst under stall, then a clean follow-up burst.
    task automatic t_reset_abort();
        int act = 0, got = 0, n_exp;
        logic [15:0] sum = 16'h0, expw;
        logic seen = 1'b0;
        n_exp = 2 + int'(CS);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 14'h0010; bus.length = 15'd8; bus.out_ready = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("rst pre busy", bus.busy, 1'b1);
        chk("rst pre out_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst mid");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid || bus.mem_ce || bus.busy || bus.done) act++;
        end
        chk("rst residual activity", act, 0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 14'h0020; bus.length = 15'd2;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                expw = (got < 2) ? (16'(32 + got) ^ 16'hA5A5) : sum;
                chk($sformatf("restart word%0d", got), bus.out_data, expw);
                chk($sformatf("restart last%0d", got), bus.out_last, (got == n_exp - 1));
                if (got < 2) sum = sum + expw;
                got++;
            end
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("restart done seen", seen, 1'b1);
        chk("restart word count", got, n_exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b1;
        bus.mem_rdata = '0;

        // Burst base 0x0010 len 4
        vt.push_back('{1, 0, 0, 14'h0000, 0, 0, 0, 16'h0000, 0});
        vt.push_back('{1, 1, 1, 14'h0010, 1, 0, 0, 16'h0000, 0});
        vt.push_back('{1, 2, 1, 14'h0011, 1, 0, 0, 16'h0000, 0});
        vt.push_back('{1, 3, 1, 14'h0012, 1, 0, 1, 16'hA5B5, 0});
        vt.push_back('{1, 4, 1, 14'h0013, 1, 0, 1, 16'hA5B4, 0});
        vt.push_back('{1, 5, 0, 14'h0000, 1, 0, 1, 16'hA5B7, 0});
        vt.push_back('{1, 6, 0, 14'h0000, 1, 0, 1, 16'hA5B6, !CS});
        vt.push_back('{1, 7, 0, 14'h0000, CS, !CS, CS, 16'h96D6, CS});
        vt.push_back('{1, 8, 0, 14'h0000, 0, CS, 0, 16'h0000, 0});
        vt.push_back('{1, 9, 0, 14'h0000, 0, 0, 0, 16'h0000, 0});
        // Address wrap base 0x3FFE len 4
        vt.push_back('{3, 1, 1, 14'h3FFE, 1, 0, 0, 16'h0000, 0});
        vt.push_back('{3, 2, 1, 14'h3FFF, 1, 0, 0, 16'h0000, 0});
        vt.push_back('{3, 3, 1, 14'h0000, 1, 0, 1, 16'h9A5B, 0});
        vt.push_back('{3, 4, 1, 14'h0001, 1, 0, 1, 16'h9A5A, 0});
        vt.push_back('{3, 5, 0, 14'h0000, 1, 0, 1, 16'hA5A5, 0});
        vt.push_back('{3, 6, 0, 14'h0000, 1, 0, 1, 16'hA5A4, !CS});
        // Zero length
        vt.push_back('{4, 0, 0, 14'h0000, 0, 0, 0, 16'h0000, 0});
        vt.push_back('{4, 1, 0, 14'h0000, 0, 1, 0, 16'h0000, 0});
        vt.push_back('{4, 2, 0, 14'h0000, 0, 0, 0, 16'h0000, 0});
        vt.push_back('{4, 3, 0, 14'h0000, 0, 0, 0, 16'h0000, 0});

        #1;
        check_idle_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_trace(14'h0010, 15'd4);
        check_scn(1);
        run_trace(14'h3FFE, 15'd4);
        check_scn(3);
        run_trace(14'h0100, 15'd0);
        check_scn(4);

        t_backpressure();
        t_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
